// File: rtl/openframe_gpio_ctrl.sv
// openframe_gpio_ctrl: register-mapped GPIO pad controller.
// Power-up safe-hold sequencing, per-pad output/OE/drive-mode/input-disable
// registers, input synchronizers and rising-edge interrupt status.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_HOLD | post-reset safe hold; bus stalled, pads at reset values
// ST_RUN  | normal operation; one request accepted per two cycles
module openframe_gpio_ctrl #(
  parameter int NUM_PADS     = 44,
  parameter int SYNC_STAGES  = 2,
  parameter int PWRUP_CYCLES = 16
) (
  input  logic                wb_clk_i,
  input  logic                resetb_l,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                cfg_we,
  input  logic [7:0]          cfg_addr,
  input  logic [31:0]         cfg_wdata,
  output logic [31:0]         cfg_rdata,
  output logic                rsp_valid,
  input  logic [NUM_PADS-1:0] gpio_in,
  output logic [NUM_PADS-1:0] gpio_out,
  output logic [NUM_PADS-1:0] gpio_oeb,
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm0,
  output logic [NUM_PADS-1:0] gpio_inp_dis,
  output logic                irq
);

  typedef enum logic {ST_HOLD = 1'b0, ST_RUN = 1'b1} state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [NUM_PADS-1:0] out_q, out_d;
  logic [NUM_PADS-1:0] oeb_q, oeb_d;
  logic [NUM_PADS-1:0] en_q, en_d;
  logic [NUM_PADS-1:0] stat_q, stat_d;
  logic [NUM_PADS-1:0] dm2_q, dm2_d;
  logic [NUM_PADS-1:0] dm1_q, dm1_d;
  logic [NUM_PADS-1:0] dm0_q, dm0_d;
  logic [NUM_PADS-1:0] inp_dis_q, inp_dis_d;
  logic [SYNC_STAGES-1:0][NUM_PADS-1:0] sync_q, sync_d;
  logic [NUM_PADS-1:0] prev_q, prev_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;

  logic                acc;
  logic                wr;
  logic [NUM_PADS-1:0] sync_in;
  logic [NUM_PADS-1:0] edge_set;
  logic [63:0]         out_x, oeb_x, in_x, en_x, stat_x;
  logic [31:0]         rd_mux;

  // FSM state register and power-up counter
  always_ff @(posedge wb_clk_i or negedge resetb_l) begin
    if (!resetb_l) begin
      state_q <= ST_HOLD;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: count out the hold window, then stay in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_HOLD) begin
      if (cnt_q == 8'(PWRUP_CYCLES - 1)) state_d = ST_RUN;
      else                               cnt_d   = cnt_q + 8'd1;
    end
  end

  // FSM outputs: ready only in RUN and never while a response is on the bus
  always_comb begin
    cfg_ready = (state_q == ST_RUN) && !rsp_valid_q;
  end

  // Register file, synchronizer advance, edge capture and read mux
  always_comb begin
    out_d     = out_q;
    oeb_d     = oeb_q;
    en_d      = en_q;
    stat_d    = stat_q;
    dm2_d     = dm2_q;
    dm1_d     = dm1_q;
    dm0_d     = dm0_q;
    inp_dis_d = inp_dis_q;

    acc = cfg_valid && cfg_ready;
    wr  = acc && cfg_we;

    sync_d   = {sync_q[SYNC_STAGES-2:0], gpio_in};
    sync_in  = sync_q[SYNC_STAGES-1];
    prev_d   = sync_in;
    edge_set = sync_in & ~prev_q & ~inp_dis_q;

    for (int i = 0; i < NUM_PADS; i++) begin
      if (wr && cfg_addr == 8'(0 + i / 32)) out_d[i] = cfg_wdata[i % 32];
      if (wr && cfg_addr == 8'(2 + i / 32)) oeb_d[i] = cfg_wdata[i % 32];
      if (wr && cfg_addr == 8'(6 + i / 32)) en_d[i]  = cfg_wdata[i % 32];
      if (wr && cfg_addr == 8'(8 + i / 32) && cfg_wdata[i % 32]) stat_d[i] = 1'b0;
      if (wr && cfg_addr == 8'(16 + i)) begin
        dm0_d[i]     = cfg_wdata[0];
        dm1_d[i]     = cfg_wdata[1];
        dm2_d[i]     = cfg_wdata[2];
        inp_dis_d[i] = cfg_wdata[3];
      end
    end
    // A new edge overrides a same-cycle clear so no event is lost
    stat_d = stat_d | edge_set;

    out_x  = '0;
    oeb_x  = '0;
    in_x   = '0;
    en_x   = '0;
    stat_x = '0;
    out_x[NUM_PADS-1:0]  = out_q;
    oeb_x[NUM_PADS-1:0]  = oeb_q;
    in_x[NUM_PADS-1:0]   = sync_in;
    en_x[NUM_PADS-1:0]   = en_q;
    stat_x[NUM_PADS-1:0] = stat_q;

    rd_mux = '0;
    case (cfg_addr)
      8'h00:   rd_mux = out_x[31:0];
      8'h01:   rd_mux = out_x[63:32];
      8'h02:   rd_mux = oeb_x[31:0];
      8'h03:   rd_mux = oeb_x[63:32];
      8'h04:   rd_mux = in_x[31:0];
      8'h05:   rd_mux = in_x[63:32];
      8'h06:   rd_mux = en_x[31:0];
      8'h07:   rd_mux = en_x[63:32];
      8'h08:   rd_mux = stat_x[31:0];
      8'h09:   rd_mux = stat_x[63:32];
      default: rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_PADS; i++) begin
      if (cfg_addr == 8'(16 + i)) rd_mux = {28'd0, inp_dis_q[i], dm2_q[i], dm1_q[i], dm0_q[i]};
    end

    rsp_valid_d = acc;
    rdata_d     = (acc && !cfg_we) ? rd_mux : 32'd0;
    irq_d       = |(stat_q & en_q);
  end

  // State flops; pads come up tristated with weak drive mode 001
  always_ff @(posedge wb_clk_i or negedge resetb_l) begin
    if (!resetb_l) begin
      out_q       <= '0;
      oeb_q       <= '1;
      en_q        <= '0;
      stat_q      <= '0;
      dm2_q       <= '0;
      dm1_q       <= '0;
      dm0_q       <= '1;
      inp_dis_q   <= '0;
      sync_q      <= '0;
      prev_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      oeb_q       <= oeb_d;
      en_q        <= en_d;
      stat_q      <= stat_d;
      dm2_q       <= dm2_d;
      dm1_q       <= dm1_d;
      dm0_q       <= dm0_d;
      inp_dis_q   <= inp_dis_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign gpio_out     = out_q;
  assign gpio_oeb     = oeb_q;
  assign gpio_dm2     = dm2_q;
  assign gpio_dm1     = dm1_q;
  assign gpio_dm0     = dm0_q;
  assign gpio_inp_dis = inp_dis_q;
  assign rsp_valid    = rsp_valid_q;
  assign cfg_rdata    = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_openframe_gpio_ctrl.sv
// Directed bench for openframe_gpio_ctrl with default parameters.
module tb_openframe_gpio_ctrl;
  localparam int NP = 44;

  logic          wb_clk_i = 1'b0;
  logic          resetb_l;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_we;
  logic [7:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;
  logic          rsp_valid;
  logic [NP-1:0] gpio_in;
  logic [NP-1:0] gpio_out, gpio_oeb, gpio_dm2, gpio_dm1, gpio_dm0, gpio_inp_dis;
  logic          irq;

  int n_chk = 0;
  int n_bad = 0;

  openframe_gpio_ctrl #(.NUM_PADS(NP), .SYNC_STAGES(2), .PWRUP_CYCLES(16)) dut (
    .wb_clk_i(wb_clk_i), .resetb_l(resetb_l),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .rsp_valid(rsp_valid), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oeb(gpio_oeb), .gpio_dm2(gpio_dm2), .gpio_dm1(gpio_dm1),
    .gpio_dm0(gpio_dm0), .gpio_inp_dis(gpio_inp_dis), .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic xact(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd);
    int n = 0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wd;
    tick();
    cfg_valid = 1'b0;
    cfg_we    = 1'b0;
    chk("rsp", rsp_valid, 1);
    rd = cfg_rdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not end, want finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    logic        ok;
    logic        seen;

    resetb_l  = 1'b0;
    cfg_valid = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 8'h00;
    cfg_wdata = 32'd0;
    gpio_in   = '0;
    repeat (3) tick();
    chk("rst_ready", cfg_ready, 0);
    chk("rst_oeb", gpio_oeb, 44'hFFF_FFFF_FFFF);
    chk("rst_dm0", gpio_dm0, 44'hFFF_FFFF_FFFF);
    chk("rst_dm1", gpio_dm1, 0);
    chk("rst_out", gpio_out, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_irq", irq, 0);

    // Power-up hold with a request pending the whole time
    resetb_l = 1'b1;
    n  = 0;
    ok = 1'b1;
    while (!cfg_ready && n < 40) begin
      if (gpio_oeb !== 44'hFFF_FFFF_FFFF || gpio_dm0 !== 44'hFFF_FFFF_FFFF || rsp_valid !== 1'b0)
        ok = 1'b0;
      n++;
      tick();
    end
    cfg_valid = 1'b0;
    chk("hold_len", n, 16);
    chk("hold_pads", ok, 1);
    chk("run_ready", cfg_ready, 1);

    // Output and OE registers
    xact(1'b1, 8'h00, 32'hA5A5_A5A5, rd);
    chk("out_lo", gpio_out[31:0], 32'hA5A5_A5A5);
    xact(1'b1, 8'h02, 32'h0, rd);
    chk("oeb_lo", gpio_oeb[31:0], 0);
    chk("oeb_hi", gpio_oeb[43:32], 12'hFFF);
    xact(1'b1, 8'h01, 32'hFFFF_FFFF, rd);
    chk("out_hi", gpio_out[43:32], 12'hFFF);
    xact(1'b0, 8'h01, 32'h0, rd);
    chk("rd_out_hi", rd, 32'h0000_0FFF);
    xact(1'b0, 8'h00, 32'h0, rd);
    chk("rd_out_lo", rd, 32'hA5A5_A5A5);
    xact(1'b0, 8'h03, 32'h0, rd);
    chk("rd_oeb_hi", rd, 32'h0000_0FFF);

    // Rising edge on pad 5 with its interrupt enabled
    xact(1'b1, 8'h06, 32'h20, rd);
    gpio_in[5] = 1'b1;
    tick();
    tick();
    xact(1'b0, 8'h04, 32'h0, rd);
    chk("in5", rd, 32'h20);
    chk("irq_pre", irq, 0);
    tick();
    chk("irq_set", irq, 1);
    xact(1'b0, 8'h08, 32'h0, rd);
    chk("stat5", rd, 32'h20);
    xact(1'b1, 8'h08, 32'h20, rd);
    chk("irq_hold", irq, 1);
    tick();
    chk("irq_clr", irq, 0);

    // Clear of pad 3 status lands in the same cycle as its edge
    gpio_in[3] = 1'b1;
    tick();
    tick();
    cfg_valid = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = 8'h08;
    cfg_wdata = 32'h08;
    tick();
    cfg_valid = 1'b0;
    cfg_we    = 1'b0;
    chk("rsp_w1c3", rsp_valid, 1);
    xact(1'b0, 8'h08, 32'h0, rd);
    chk("stat3_wins", rd, 32'h08);
    chk("irq_gated", irq, 0);

    // Pad configuration
    xact(1'b1, 8'h17, 32'hFFFF_FFF5, rd);
    chk("dm7_a", {gpio_dm2[7], gpio_dm1[7], gpio_dm0[7]}, 3'b101);
    chk("dis7_a", gpio_inp_dis[7], 0);
    xact(1'b0, 8'h17, 32'h0, rd);
    chk("rd_pcfg7", rd, 32'h5);
    xact(1'b1, 8'h17, 32'hF, rd);
    chk("dm7_b", {gpio_dm2[7], gpio_dm1[7], gpio_dm0[7]}, 3'b111);
    chk("dis7_b", gpio_inp_dis[7], 1);
    chk("dm8", {gpio_dm2[8], gpio_dm1[8], gpio_dm0[8]}, 3'b001);
    gpio_in[7] = 1'b1;
    repeat (5) tick();
    xact(1'b0, 8'h08, 32'h0, rd);
    chk("stat7_off", rd, 32'h08);
    xact(1'b0, 8'h04, 32'h0, rd);
    chk("in_all", rd, 32'hA8);
    xact(1'b1, 8'h3C, 32'hF, rd);
    xact(1'b0, 8'h3C, 32'h0, rd);
    chk("pcfg44", rd, 0);
    xact(1'b0, 8'h0A, 32'h0, rd);
    chk("unmapped", rd, 0);

    // Reset right after a write is accepted
    tick();
    n = 0;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    cfg_valid = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = 8'h00;
    cfg_wdata = 32'h1234_5678;
    tick();
    chk("pre_rst_out", gpio_out[31:0], 32'h1234_5678);
    resetb_l  = 1'b0;
    cfg_valid = 1'b0;
    cfg_we    = 1'b0;
    #1;
    chk("ar_out", gpio_out, 0);
    chk("ar_oeb", gpio_oeb, 44'hFFF_FFFF_FFFF);
    chk("ar_dm0", gpio_dm0, 44'hFFF_FFFF_FFFF);
    chk("ar_dis", gpio_inp_dis, 0);
    chk("ar_rsp", rsp_valid, 0);
    chk("ar_ready", cfg_ready, 0);
    chk("ar_rdata", cfg_rdata, 0);
    tick();
    resetb_l = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp", seen, 0);
    chk("post_out", gpio_out, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/openframe_gpio_ctrl.md
OPENFRAME_GPIO_CTRL -- requirements
Module: openframe_gpio_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_PADS, default 44, number of managed GPIO pads; legal range 1..64.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..4.
REQ-003 The module SHALL have parameter PWRUP_CYCLES, default 16, cycles spent in safe-hold after reset; legal range 1..255.
REQ-004 The module SHALL have port wb_clk_i  input  1  single clock for all logic.
REQ-005 The module SHALL have port resetb_l  input  1  reset, asynchronous assert, active-low, 1.8V domain.
REQ-006 The module SHALL have port cfg_valid  input  1  register request valid.
REQ-007 The module SHALL have port cfg_ready  output  1  request accepted when cfg_valid & cfg_ready.
REQ-008 The module SHALL have port cfg_we  input  1  1 = write, 0 = read.
REQ-009 The module SHALL have port cfg_addr  input  8  word address.
REQ-010 The module SHALL have port cfg_wdata  input  32  write data.
REQ-011 The module SHALL have port cfg_rdata  output  32  read data, qualified by rsp_valid.
REQ-012 The module SHALL have port rsp_valid  output  1  one-cycle pulse completing every accepted request.
REQ-013 The module SHALL have port gpio_in  input  NUM_PADS  asynchronous pad inputs.
REQ-014 The module SHALL have ports gpio_out and gpio_oeb  output  NUM_PADS each  pad data out and output-enable (active-low).
REQ-015 The module SHALL have ports gpio_dm2, gpio_dm1, gpio_dm0 and gpio_inp_dis  output  NUM_PADS each  per-pad drive mode and input disable.
REQ-016 The module SHALL have port irq  output  1  level interrupt.

Function
REQ-017 Register map (32-bit; bit i = pad i for the first 32 pads, pad 32+i for the second): 0x00/0x01 OUT lo/hi RW; 0x02/0x03 OEB lo/hi RW; 0x04/0x05 IN lo/hi RO (synchronized); 0x06/0x07 IRQ_EN lo/hi RW; 0x08/0x09 IRQ_STAT lo/hi W1C; 0x10+p PADCFG[p] for p < NUM_PADS, bits[2:0]=dm[2:0], bit[3]=inp_dis, other bits read 0.
REQ-018 Bits for pads >= NUM_PADS, unmapped addresses and PADCFG beyond NUM_PADS SHALL read 0 and ignore writes; the request still completes with rsp_valid.
REQ-019 The controller SHALL implement FSM HOLD -> RUN; after reset it enters HOLD with an 8-bit counter = 0 and moves to RUN when the counter reaches PWRUP_CYCLES-1; RUN is terminal until reset.
REQ-020 In HOLD, cfg_ready=0 and pad outputs SHALL carry reset values; register writes are impossible.
REQ-021 In RUN, cfg_ready SHALL be 1 except in the cycle that rsp_valid=1, giving at most one request per two cycles.
REQ-022 An accepted request at cycle N SHALL update registers at the edge ending cycle N, with rsp_valid=1 in cycle N+1; for reads, cfg_rdata holds data sampled at cycle N; otherwise cfg_rdata=0.
REQ-023 gpio_out, gpio_oeb, gpio_dm*, gpio_inp_dis SHALL be driven directly from registers, with no combinational path from cfg_* to pad outputs.
REQ-024 Each gpio_in bit SHALL pass a SYNC_STAGES flop chain; IN reads the last stage.
REQ-025 A rising edge (previous synced value 0, current 1) on pad i SHALL set IRQ_STAT[i] regardless of IRQ_EN; bits with inp_dis=1 never set.
REQ-026 If a W1C write and a new edge hit the same IRQ_STAT bit in one cycle, the set SHALL win.
REQ-027 irq SHALL equal the registered OR of (IRQ_STAT & IRQ_EN), asserting one cycle after the enabling condition.

Reset
REQ-028 On resetb_l low, all state SHALL clear asynchronously: FSM=HOLD, counter=0, gpio_out=0, gpio_oeb=all 1, dm=3'b001 per pad, gpio_inp_dis=0, IRQ_EN=0, IRQ_STAT=0, sync flops=0, irq=0, cfg_ready=0, rsp_valid=0, cfg_rdata=0.
REQ-029 Reset asserted mid-transaction SHALL abort it; no rsp_valid is produced after deassertion for the aborted request.

Verification
REQ-030 Release reset, hold cfg_valid=1 -> cfg_ready=0 for exactly 16 cycles, then 1; gpio_oeb reads all ones and dm0=all ones throughout HOLD.
REQ-031 Write 0x00=0xA5A5A5A5 and 0x02=0x0 -> gpio_out[31:0]=0xA5A5A5A5 and gpio_oeb[31:0]=0 the cycle after acceptance; read 0x01 -> bits above pad 43 read 0.
REQ-032 Drive gpio_in[5] 0->1 with IRQ_EN[5]=1 -> IN bit 5 visible after 2 cycles, IRQ_STAT[5]=1, irq=1 one cycle later; W1C 0x08=0x20 -> irq=0.
REQ-033 W1C IRQ_STAT[3] in the same cycle pad 3's synchronized edge arrives -> IRQ_STAT[3] remains 1.
REQ-034 Write PADCFG 0x17=0xF (pad 7) -> gpio_dm[7]=3'b111, gpio_inp_dis[7]=1; edges on pad 7 leave IRQ_STAT[7]=0; write to 0x10+44 -> rsp_valid, reads 0.
REQ-035 Assert resetb_l low the cycle after accepting a write -> all outputs return to reset values immediately and no rsp_valid follows release.
